// File: rtl/ac_lockin_detector.sv
// rtl/ac_lockin_detector.sv - multi-channel square-wave quadrature lock-in detector
//
// Optional feature macro: AC_LOCKIN_DC_EN (adds res_dc and per-channel DC sums).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          run control (abort wins over everything)
//   ftw, n_settle, n_integ run setup, latched on an accepted start
//   s_valid/s_ready/s_data sample stream, channel k at s_data[k*DW +: DW]
//   res_valid/res_ready   per-channel result handshake
//   res_ch, res_i, res_q, res_ovf (, res_dc) result payload
//   busy, done            run status; done pulses after the last result
module ac_lockin_detector #(
  parameter int CH    = 2,
  parameter int DW    = 16,
  parameter int PW    = 24,
  parameter int NW    = 16,
  parameter int ACC_W = 48,
  localparam int CW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PW-1:0]        ftw,
  input  logic [NW-1:0]        n_settle,
  input  logic [NW-1:0]        n_integ,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [CH*DW-1:0]     s_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CW-1:0]        res_ch,
  output logic [ACC_W-1:0]     res_i,
  output logic [ACC_W-1:0]     res_q,
  output logic                 res_ovf,
  output logic                 busy,
  output logic                 done
`ifdef AC_LOCKIN_DC_EN
  ,
  output logic [ACC_W-1:0]     res_dc
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_INTEG, S_OUT} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t            state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [PW-1:0]     ftw_q, ftw_d;
  logic [NW-1:0]     cyc_cnt_q, cyc_cnt_d;
  logic [NW-1:0]     n_settle_q, n_settle_d;
  logic [NW-1:0]     n_integ_q, n_integ_d;
  logic [ACC_W-1:0]  acc_i_q [CH];
  logic [ACC_W-1:0]  acc_i_d [CH];
  logic [ACC_W-1:0]  acc_q_q [CH];
  logic [ACC_W-1:0]  acc_q_d [CH];
  logic              ovf_q [CH];
  logic              ovf_d [CH];
  logic              res_valid_q, res_valid_d;
  logic [CW-1:0]     res_ch_q, res_ch_d;
  logic [ACC_W-1:0]  res_i_q, res_i_d;
  logic [ACC_W-1:0]  res_q_q, res_q_d;
  logic              res_ovf_q, res_ovf_d;
  logic              done_q, done_d;
`ifdef AC_LOCKIN_DC_EN
  logic [ACC_W-1:0]  acc_dc_q [CH];
  logic [ACC_W-1:0]  acc_dc_d [CH];
  logic [ACC_W-1:0]  res_dc_q, res_dc_d;
  logic [ACC_W:0]    sum_dc;
`endif

  logic              accepted;
  logic              carry;
  logic [PW-1:0]     phase_sum;
  logic              i_neg, q_neg;
  logic [ACC_W-1:0]  x_ext;
  logic [ACC_W:0]    sum_i, sum_q;
  logic [CW-1:0]     load_ch;

  // Returns {overflowed, clamped two's-complement sum}.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) return {1'b1, (s[ACC_W] ? ACC_MIN : ACC_MAX)};
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  assign accepted           = s_valid && (state_q != S_OUT);
  assign {carry, phase_sum} = {1'b0, phase_q} + {1'b0, ftw_q};
  // I reference is a cosine-like square (negative in quadrants 1 and 2),
  // Q reference is a sine-like square (negative in quadrants 2 and 3).
  assign i_neg              = phase_q[PW-1] ^ phase_q[PW-2];
  assign q_neg              = phase_q[PW-1];

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    ftw_d       = ftw_q;
    cyc_cnt_d   = cyc_cnt_q;
    n_settle_d  = n_settle_q;
    n_integ_d   = n_integ_q;
    acc_i_d     = acc_i_q;
    acc_q_d     = acc_q_q;
    ovf_d       = ovf_q;
    res_valid_d = res_valid_q;
    res_ch_d    = res_ch_q;
    res_i_d     = res_i_q;
    res_q_d     = res_q_q;
    res_ovf_d   = res_ovf_q;
    done_d      = 1'b0;
    x_ext       = '0;
    sum_i       = '0;
    sum_q       = '0;
    load_ch     = res_ch_q;
`ifdef AC_LOCKIN_DC_EN
    acc_dc_d    = acc_dc_q;
    res_dc_d    = res_dc_q;
    sum_dc      = '0;
`endif

    unique case (state_q)
      S_IDLE: begin
        // done_q high means the previous run ended on the last edge; a start
        // arriving alongside that pulse belongs to the old run and is dropped.
        if (start && !done_q) begin
          ftw_d      = ftw;
          n_settle_d = n_settle;
          n_integ_d  = (n_integ == '0) ? NW'(1) : n_integ;
          phase_d    = '0;
          cyc_cnt_d  = '0;
          for (int k = 0; k < CH; k++) begin
            acc_i_d[k] = '0;
            acc_q_d[k] = '0;
            ovf_d[k]   = 1'b0;
`ifdef AC_LOCKIN_DC_EN
            acc_dc_d[k] = '0;
`endif
          end
          state_d = (n_settle == '0) ? S_INTEG : S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (accepted) begin
          phase_d = phase_sum;
          if (carry) begin
            if (cyc_cnt_q == n_settle_q - NW'(1)) begin
              cyc_cnt_d = '0;
              state_d   = S_INTEG;
            end else begin
              cyc_cnt_d = cyc_cnt_q + NW'(1);
            end
          end
        end
      end

      S_INTEG: begin
        if (accepted) begin
          phase_d = phase_sum;
          for (int k = 0; k < CH; k++) begin
            x_ext = {{(ACC_W-DW){s_data[k*DW+DW-1]}}, s_data[k*DW +: DW]};
            sum_i = sat_add(acc_i_q[k], i_neg ? -x_ext : x_ext);
            sum_q = sat_add(acc_q_q[k], q_neg ? -x_ext : x_ext);
            acc_i_d[k] = sum_i[ACC_W-1:0];
            acc_q_d[k] = sum_q[ACC_W-1:0];
            ovf_d[k]   = ovf_q[k] | sum_i[ACC_W] | sum_q[ACC_W];
`ifdef AC_LOCKIN_DC_EN
            sum_dc      = sat_add(acc_dc_q[k], x_ext);
            acc_dc_d[k] = sum_dc[ACC_W-1:0];
            ovf_d[k]    = ovf_d[k] | sum_dc[ACC_W];
`endif
          end
          if (carry) begin
            if (cyc_cnt_q == n_integ_q - NW'(1)) begin
              cyc_cnt_d = '0;
              res_ch_d  = '0;
              state_d   = S_OUT;
            end else begin
              cyc_cnt_d = cyc_cnt_q + NW'(1);
            end
          end
        end
      end

      S_OUT: begin
        // First OUT cycle loads channel 0; afterwards each handshake loads the
        // next channel directly so results stream at one per cycle.
        if (!res_valid_q) begin
          res_valid_d = 1'b1;
        end else if (res_ready) begin
          if (res_ch_q == CW'(CH-1)) begin
            res_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end else begin
            load_ch  = res_ch_q + CW'(1);
            res_ch_d = load_ch;
          end
        end
        if (res_valid_d && (!res_valid_q || res_ready)) begin
          for (int k = 0; k < CH; k++) begin
            if (CW'(k) == load_ch) begin
              res_i_d   = acc_i_q[k];
              res_q_d   = acc_q_q[k];
              res_ovf_d = ovf_q[k];
`ifdef AC_LOCKIN_DC_EN
              res_dc_d  = acc_dc_q[k];
`endif
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d     = S_IDLE;
      res_valid_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      ftw_q       <= '0;
      cyc_cnt_q   <= '0;
      n_settle_q  <= '0;
      n_integ_q   <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_i_q     <= '0;
      res_q_q     <= '0;
      res_ovf_q   <= 1'b0;
      done_q      <= 1'b0;
      for (int k = 0; k < CH; k++) begin
        acc_i_q[k] <= '0;
        acc_q_q[k] <= '0;
        ovf_q[k]   <= 1'b0;
`ifdef AC_LOCKIN_DC_EN
        acc_dc_q[k] <= '0;
`endif
      end
`ifdef AC_LOCKIN_DC_EN
      res_dc_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      ftw_q       <= ftw_d;
      cyc_cnt_q   <= cyc_cnt_d;
      n_settle_q  <= n_settle_d;
      n_integ_q   <= n_integ_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_i_q     <= res_i_d;
      res_q_q     <= res_q_d;
      res_ovf_q   <= res_ovf_d;
      done_q      <= done_d;
      for (int k = 0; k < CH; k++) begin
        acc_i_q[k] <= acc_i_d[k];
        acc_q_q[k] <= acc_q_d[k];
        ovf_q[k]   <= ovf_d[k];
`ifdef AC_LOCKIN_DC_EN
        acc_dc_q[k] <= acc_dc_d[k];
`endif
      end
`ifdef AC_LOCKIN_DC_EN
      res_dc_q    <= res_dc_d;
`endif
    end
  end

  assign s_ready   = (state_q != S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = res_valid_q;
  assign res_ch    = res_ch_q;
  assign res_i     = res_i_q;
  assign res_q     = res_q_q;
  assign res_ovf   = res_ovf_q;
  assign done      = done_q;
`ifdef AC_LOCKIN_DC_EN
  assign res_dc    = res_dc_q;
`endif

endmodule

// File: tb/tb_ac_lockin_detector.sv
// tb/tb_ac_lockin_detector.sv - self-checking bench for ac_lockin_detector
module tb_ac_lockin_detector;

  localparam int CH    = 2;
  localparam int DW    = 16;
  localparam int PW    = 8;
  localparam int NW    = 16;
  localparam int ACC_W = 18;
  localparam longint AMAX = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint AMIN = -(longint'(1) <<< (ACC_W-1));
  localparam int PMOD  = 1 << PW;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start, abort;
  logic [PW-1:0]           ftw;
  logic [NW-1:0]           n_settle, n_integ;
  logic                    s_valid, s_ready;
  logic [CH*DW-1:0]        s_data;
  logic                    res_valid, res_ready;
  logic [0:0]              res_ch;
  logic signed [ACC_W-1:0] res_i, res_q;
  logic                    res_ovf, busy, done;
`ifdef AC_LOCKIN_DC_EN
  logic signed [ACC_W-1:0] res_dc;
`endif

  ac_lockin_detector #(.CH(CH), .DW(DW), .PW(PW), .NW(NW), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ftw(ftw),
    .n_settle(n_settle), .n_integ(n_integ), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_i(res_i), .res_q(res_q), .res_ovf(res_ovf), .busy(busy), .done(done)
`ifdef AC_LOCKIN_DC_EN
    , .res_dc(res_dc)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  longint m_i [CH];
  longint m_q [CH];
  longint m_dc [CH];
  bit     m_ovf [CH];
  longint got_i [CH];
  longint got_q [CH];
  logic   got_ovf [CH];

  int pat_a [4] = '{100, 100, -100, -100};
  int pat_b [4] = '{100, -100, -100, 100};

  task automatic check(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint clamp(longint v, int ch);
    if (v > AMAX) begin m_ovf[ch] = 1'b1; return AMAX; end
    if (v < AMIN) begin m_ovf[ch] = 1'b1; return AMIN; end
    return v;
  endfunction

  // k = index of the sample within the integration window
  function automatic longint gen(int mode, int ch, int k, bit settling);
    logic signed [DW-1:0] r;
    case (mode)
      1: return (ch == 0) ? pat_a[k%4] : pat_b[k%4];
      2: return 100;
      3: return settling ? 30000 : pat_b[k%4];
      4: return (ch == 0) ? ((k % 4 < 2) ? 32767 : -32767) : 5;
      default: begin r = DW'($urandom); return longint'(r); end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_run(string tag, int f, int ns, int ni, int mode, bit stall, bit rst_mid);
    int n, c, k, total, p, quad, si, sq;
    bit carry, settling;
    longint x;
    for (int ch = 0; ch < CH; ch++) begin
      m_i[ch] = 0; m_q[ch] = 0; m_dc[ch] = 0; m_ovf[ch] = 1'b0;
    end
    ftw = PW'(f); n_settle = NW'(ns); n_integ = NW'(ni); start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    n = 0; c = 0; k = 0;
    total = ns + ((ni == 0) ? 1 : ni);
    while (c < total) begin
      p = (n * f) % PMOD;
      carry = (p + f) >= PMOD;
      settling = (c < ns);
      quad = p / (PMOD / 4);
      si = (quad == 0 || quad == 3) ? 1 : -1;
      sq = (quad < 2) ? 1 : -1;
      for (int ch = 0; ch < CH; ch++) begin
        x = gen(mode, ch, k, settling);
        s_data[ch*DW +: DW] = DW'(x);
        if (!settling) begin
          m_i[ch]  = clamp(m_i[ch] + si * x, ch);
          m_q[ch]  = clamp(m_q[ch] + sq * x, ch);
          m_dc[ch] = clamp(m_dc[ch] + x, ch);
        end
      end
`ifndef AC_LOCKIN_DC_EN
      for (int ch = 0; ch < CH; ch++) m_dc[ch] = 0;
`endif
      if (!settling) k++;
      n++;
      if (carry) c++;
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      if (c < total && $urandom_range(0, 3) == 0) tick();
    end
    check({tag, "_out_latency_valid"}, res_valid, 0);
    check({tag, "_out_sready"}, s_ready, 0);
    tick();
    for (int ch = 0; ch < CH; ch++) begin
      if (stall && ch == 0) begin
        res_ready = 1'b0;
        for (int w = 0; w < 5; w++) begin
          s_valid = 1'b1;
          s_data = CH*DW'($urandom);
          check({tag, "_stall_ch"}, res_ch, 0);
          check({tag, "_stall_i"}, res_i, m_i[0]);
          check({tag, "_stall_sready"}, s_ready, 0);
          tick();
        end
        s_valid = 1'b0;
      end
      check({tag, "_valid"}, res_valid, 1);
      check({tag, "_ch"}, res_ch, ch);
      check({tag, "_i"}, res_i, m_i[ch]);
      check({tag, "_q"}, res_q, m_q[ch]);
      check({tag, "_ovf"}, res_ovf, m_ovf[ch]);
`ifdef AC_LOCKIN_DC_EN
      check({tag, "_dc"}, res_dc, m_dc[ch]);
`endif
      got_i[ch] = res_i; got_q[ch] = res_q; got_ovf[ch] = res_ovf;
      if (rst_mid) begin
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_rst_valid"}, res_valid, 0);
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_sready"}, s_ready, 1);
        check({tag, "_rst_i"}, res_i, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check({tag, "_rst_done"}, done, 0);
        return;
      end
      res_ready = 1'b1;
      tick();
      if (ch < CH - 1) check({tag, "_no_early_done"}, done, 0);
    end
    res_ready = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_done_busy"}, busy, 0);
    check({tag, "_done_valid"}, res_valid, 0);
    // start coinciding with done must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_start_at_done_ignored"}, busy, 0);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ftw = '0; n_settle = '0; n_integ = '0;
    s_valid = 1'b0; s_data = '0; res_ready = 1'b0;
    #12;
    check("rst_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sready", s_ready, 1);
    check("rst_i", res_i, 0);
    check("rst_q", res_q, 0);
    check("rst_ch", res_ch, 0);
    check("rst_ovf", res_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    do_run("quad", 64, 0, 1, 1, 1'b0, 1'b0);
    check("quad_ch0_i", got_i[0], 0);
    check("quad_ch0_q", got_q[0], 400);
    check("quad_ch1_i", got_i[1], 400);
    check("quad_ch1_q", got_q[1], 0);

    do_run("const", 64, 0, 1, 2, 1'b0, 1'b0);
    check("const_i", got_i[0], 0);
    check("const_q", got_q[1], 0);

    do_run("settle", 64, 2, 1, 3, 1'b0, 1'b0);
    check("settle_i", got_i[0], 400);

    do_run("sat", 64, 0, 4, 4, 1'b0, 1'b0);
    check("sat_q", got_q[0], AMAX);
    check("sat_ovf", got_ovf[0], 1);
    do_run("post_sat", 64, 0, 1, 1, 1'b0, 1'b0);
    check("post_sat_ovf", got_ovf[0], 0);

    do_run("stall", 64, 0, 0, 1, 1'b1, 1'b0);

    // abort mid-integration, together with a start
    ftw = 8'd64; n_settle = '0; n_integ = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin s_valid = 1'b1; s_data = '0; tick(); end
    s_valid = 1'b0;
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", res_valid, 0);
    check("abort_done", done, 0);
    for (int j = 0; j < 4; j++) begin tick(); check("abort_no_valid", res_valid, 0); end

    // ftw = 0 never completes a cycle
    ftw = '0; n_settle = 16'd1; n_integ = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    s_valid = 1'b1;
    repeat (20) tick();
    s_valid = 1'b0;
    check("ftw0_still_busy", busy, 1);
    check("ftw0_no_valid", res_valid, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ftw0_abort_busy", busy, 0);

    do_run("rst_mid", 64, 0, 1, 1, 1'b0, 1'b1);
    do_run("fresh", 64, 0, 1, 1, 1'b0, 1'b0);
    check("fresh_ch0_q", got_q[0], 400);
    check("fresh_ch1_i", got_i[1], 400);

    for (int r = 0; r < 6; r++) begin
      do_run("rand", $urandom_range(17, 127), $urandom_range(0, 2), $urandom_range(0, 3), 0,
             1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
